// File: rtl/snap_pkg.sv
// snap_pkg: shared capture FSM states and control-word bit positions
package snap_pkg;
  typedef enum logic [2:0] {IDLE, PRE, WAIT, DELAY, CAPT, DONE} state_t;
  localparam int CTRL_ARM       = 0;
  localparam int CTRL_SOFT_EN   = 1;
  localparam int CTRL_SOFT_TRIG = 2;
endpackage

// File: rtl/snap_edge_det.sv
// snap_edge_det: rising-edge detector that ignores a level already high when reset releases
module snap_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic q, vld;
  // previous level plus a flag that blocks the first post-reset cycle from looking like an edge
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, vld} <= 2'b00;
    else {q, vld} <= {d, 1'b1};
  assign rise = vld && d && !q;
endmodule

// File: rtl/snap_trig_ctrl.sv
// snap_trig_ctrl: armed pre/post-trigger snapshot capture into a circular buffer
module snap_trig_ctrl
  import snap_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              user_clk,
  input  logic              user_rst,
  input  logic [31:0]       ctrl,
  input  logic [31:0]       trig_offset,
  input  logic [DATA_W-1:0] din,
  input  logic              din_vld,
  input  logic              trig,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_data,
  output logic              busy,
  output logic              done,
  output logic [31:0]       status_addr
);
  localparam logic [ADDR_W:0] D    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [31:0]     D_M1 = {{(32-ADDR_W){1'b0}}, {ADDR_W{1'b1}}};
  state_t state, state_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [ADDR_W:0] cnt, cnt_n, wc, wc_n, post, post_n;
  logic [31:0] off, off_n, dly, dly_n, neg_off, rem;
  logic arm, soft_trig, trg, wr, cw;
  logic unused;
  snap_edge_det u_arm  (.clk(user_clk), .rst(user_rst), .d(ctrl[CTRL_ARM]),       .rise(arm));
  snap_edge_det u_soft (.clk(user_clk), .rst(user_rst), .d(ctrl[CTRL_SOFT_TRIG]), .rise(soft_trig));
  assign trg     = ctrl[CTRL_SOFT_EN] ? soft_trig : trig;
  assign neg_off = 32'd0 - trig_offset;
  assign rem     = off - {31'd0, din_vld};
  assign busy    = state inside {PRE, WAIT, DELAY, CAPT};
  assign done    = state == DONE;
  assign unused  = ^ctrl[31:CTRL_SOFT_TRIG+1];
  // next-state: arm restarts from anywhere; the trigger-cycle sample counts as post-trigger sample 1
  always_comb begin
    state_n = state;
    addr_n  = addr;
    cnt_n   = cnt;
    wc_n    = wc;
    dly_n   = dly;
    off_n   = off;
    post_n  = post;
    wr      = 1'b0;
    cw      = 1'b0;
    if (arm) begin
      off_n   = trig_offset;
      addr_n  = '0;
      cnt_n   = '0;
      wc_n    = '0;
      state_n = trig_offset[31] ? PRE : WAIT;
      post_n  = !trig_offset[31] ? D : neg_off >= D_M1 ? ONE : D - neg_off[ADDR_W:0];
    end else begin
      case (state)
        PRE: begin
          wr      = din_vld;
          cw      = din_vld && trg;
          state_n = trg ? CAPT : PRE;
        end
        WAIT: if (trg) begin
          if (off[31] || off == 32'd0) begin
            wr      = din_vld;
            cw      = din_vld;
            state_n = CAPT;
          end else begin
            dly_n   = rem;
            state_n = rem == 32'd0 ? CAPT : DELAY;
          end
        end
        DELAY: if (din_vld) begin
          dly_n   = dly - 32'd1;
          state_n = dly == 32'd1 ? CAPT : DELAY;
        end
        CAPT: begin
          wr = din_vld;
          cw = din_vld;
        end
        default: ;
      endcase
      addr_n = wr ? addr + 1'b1 : addr;
      cnt_n  = (wr && state == PRE && !cnt[ADDR_W]) ? cnt + 1'b1 : cnt;
      wc_n   = cw ? wc + 1'b1 : wc;
      if (cw && wc_n == post) state_n = DONE;
    end
  end
  // capture state registers
  always_ff @(posedge user_clk or posedge user_rst)
    if (user_rst) begin
      state <= IDLE;
      addr  <= '0;
      cnt   <= '0;
      wc    <= '0;
      post  <= '0;
      off   <= '0;
      dly   <= '0;
    end else begin
      state <= state_n;
      addr  <= addr_n;
      cnt   <= cnt_n;
      wc    <= wc_n;
      post  <= post_n;
      off   <= off_n;
      dly   <= dly_n;
    end
  // buffer write port one cycle behind the sample; status tracks the last written address
  always_ff @(posedge user_clk or posedge user_rst)
    if (user_rst) begin
      bram_we     <= 1'b0;
      bram_addr   <= '0;
      bram_data   <= '0;
      status_addr <= '0;
    end else begin
      bram_we   <= wr;
      bram_addr <= addr;
      bram_data <= din;
      if (wr) status_addr <= {{(32-ADDR_W){1'b0}}, addr};
    end
endmodule
